// File: rtl/float_intm.sv
// IEEE-754 single to 16-bit unsigned integer converter.
// Truncates toward zero and saturates out-of-range inputs with an error flag.
module float_intm (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        start_trig,
  input  logic [31:0] data_float,
  output logic [15:0] result_int,
  output logic        done,
  output logic        err,
  output logic        busy
);

  localparam int unsigned FW = 32;
  localparam int unsigned MW = 24;
  localparam int unsigned CW = 5;
  localparam int unsigned RW = 16;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   data_q, data_d;
  logic [MW-1:0]   mag_q, mag_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_pend_q, err_pend_d;
  logic [RW-1:0]   result_q, result_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic            sgn;
  logic [7:0]      expo;
  logic [22:0]     mant;

  assign sgn  = data_q[31];
  assign expo = data_q[30:23];
  assign mant = data_q[22:0];

  // State and output registers
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      mag_q      <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
      result_q   <= result_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; fixed results are parked in mag_q so DONE has one source
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    err_pend_d = err_pend_q;
    result_d   = result_q;
    err_d      = err_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_trig) begin
          data_d  = data_float;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_DONE;
        mag_d   = '0;
        if (expo == 8'hFF) begin
          mag_d      = sgn ? MW'(0) : MW'(16'hFFFF);
          err_pend_d = 1'b1;
        end else if (expo == 8'd0 || expo < 8'd127) begin
          err_pend_d = 1'b0;
        end else if (sgn) begin
          err_pend_d = 1'b1;
        end else if (expo >= 8'd143) begin
          mag_d      = MW'(16'hFFFF);
          err_pend_d = 1'b1;
        end else begin
          mag_d      = {1'b1, mant};
          cnt_d      = CW'(8'd150 - expo);
          err_pend_d = 1'b0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        mag_d = mag_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        result_d = mag_q[RW-1:0];
        err_d    = err_pend_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign result_int = result_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_float_intm.sv
// Scoreboard bench for float_intm against a real-arithmetic reference model.
module tb_float_intm;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic        start_trig;
  logic [31:0] data_float;
  logic [15:0] result_int;
  logic        done;
  logic        err;
  logic        busy;

  float_intm dut (
    .clk_sys    (clk_sys),
    .rst_sys_n  (rst_sys_n),
    .start_trig (start_trig),
    .data_float (data_float),
    .result_int (result_int),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [15:0] res;
    logic        er;
    int          edge_no;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          free_edge = 0;
  int          acc_cnt = 0;
  bit          rst_edge = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_res = '0;
  logic        last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h (edge %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: value-level conversion, lat = edges after the accept edge
  task automatic ref_model(input logic [31:0] f, output logic [15:0] r,
                           output logic e, output int lat);
    int  ex;
    real v;
    ex  = int'(f[30:23]);
    lat = 2;
    if (ex == 255) begin
      r = f[31] ? 16'h0000 : 16'hFFFF;
      e = 1'b1;
    end else begin
      v = (ex == 0) ? 0.0 : (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (ex - 127));
      if (f[31]) v = -v;
      if (v <= -1.0) begin
        r = 16'h0000; e = 1'b1;
      end else if (v < 1.0) begin
        r = 16'h0000; e = 1'b0;
      end else if (v >= 65536.0) begin
        r = 16'hFFFF; e = 1'b1;
      end else begin
        r   = 16'($rtoi(v));
        e   = 1'b0;
        lat = 2 + (150 - ex);
      end
    end
  endtask

  // Model: decide acceptance from inputs and predicted availability
  always @(posedge clk_sys) begin
    exp_t x;
    int   lat;
    cyc++;
    rst_edge = !rst_sys_n;
    if (!rst_sys_n) begin
      q.delete();
      free_edge = cyc + 1;
    end else if (start_trig && cyc >= free_edge) begin
      ref_model(data_float, x.res, x.er, lat);
      x.edge_no = cyc + lat;
      q.push_back(x);
      free_edge = cyc + lat + 1;
      acc_cnt++;
    end
  end

  // Monitor: compare DUT outputs just after each edge
  always @(posedge clk_sys) begin
    exp_t x;
    #1;
    if (rst_edge) begin
      chk("rst_result", 32'(result_int), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      last_res = '0;
      last_err = 1'b0;
    end else begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'h0);
        end else begin
          x = q.pop_front();
          chk("result", 32'(result_int), 32'(x.res));
          chk("err", 32'(err), 32'(x.er));
          chk("latency_edge", 32'(cyc), 32'(x.edge_no));
          last_res = x.res;
          last_err = x.er;
        end
      end else begin
        chk("hold_result", 32'(result_int), 32'(last_res));
        chk("hold_err", 32'(err), 32'(last_err));
        if (q.size() > 0 && cyc >= q[0].edge_no) begin
          chk("missing_done", 32'(done), 32'h1);
          void'(q.pop_front());
        end
      end
      chk("busy", 32'(busy), 32'(q.size() > 0));
    end
  end

  function automatic logic [31:0] rand_float();
    int unsigned sel, ex;
    logic        s;
    sel = $urandom_range(0, 7);
    ex  = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(118, 150);
    s   = ($urandom_range(0, 3) == 0);
    return {s, 8'(ex), 23'($urandom)};
  endfunction

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'h0);
  endtask

  task automatic run_one(input logic [31:0] d);
    int a0, n;
    @(negedge clk_sys);
    start_trig = 1'b1;
    data_float = d;
    a0 = acc_cnt;
    n  = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (acc_cnt == a0 && n < 60);
    if (acc_cnt == a0) chk("accept_timeout", 32'(acc_cnt), 32'(a0 + 1));
    start_trig = 1'b0;
    data_float = $urandom;
    wait_drain(60);
  endtask

  logic [31:0] dir_vec [14] = '{
    32'h3F800000, 32'h477FFF00, 32'h449A5800, 32'h47800000, 32'h7FC00000,
    32'hC0A00000, 32'hBF000000, 32'h00000000, 32'h41200000, 32'h7F800000,
    32'hFF800000, 32'h3F7FFFFF, 32'h80000000, 32'h00000001
  };

  initial begin
    rst_sys_n  = 1'b0;
    start_trig = 1'b0;
    data_float = '0;
    repeat (3) @(negedge clk_sys);
    rst_sys_n = 1'b1;

    foreach (dir_vec[i]) run_one(dir_vec[i]);

    // Reset during SHIFT of 1.0 aborts; next conversion is clean
    @(negedge clk_sys);
    start_trig = 1'b1;
    data_float = 32'h3F800000;
    @(negedge clk_sys);
    start_trig = 1'b0;
    repeat (6) @(negedge clk_sys);
    rst_sys_n = 1'b0;
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    repeat (30) @(negedge clk_sys);
    run_one(32'h41200000);

    // Reset wins over a simultaneous start
    @(negedge clk_sys);
    rst_sys_n  = 1'b0;
    start_trig = 1'b1;
    data_float = 32'h41200000;
    @(negedge clk_sys);
    rst_sys_n  = 1'b1;
    start_trig = 1'b0;
    repeat (3) @(negedge clk_sys);

    // start_trig held high: back-to-back conversions
    start_trig = 1'b1;
    for (int i = 0; i < 150; i++) begin
      data_float = rand_float();
      @(negedge clk_sys);
    end
    start_trig = 1'b0;
    wait_drain(60);

    // Random traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      start_trig = ($urandom_range(0, 3) == 0);
      data_float = rand_float();
      rst_sys_n  = ($urandom_range(0, 99) != 0);
      @(negedge clk_sys);
    end
    rst_sys_n  = 1'b1;
    start_trig = 1'b0;
    wait_drain(60);
    repeat (5) @(negedge clk_sys);
    chk("final_queue_empty", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
